// File: rtl/aclock_pkg.sv
// Shared types, digit limits and digit-increment helpers for the alarm-clock time/alarm entry controller.
package aclock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EDIT_H1 = 3'd1,
        ST_EDIT_H0 = 3'd2,
        ST_EDIT_M1 = 3'd3,
        ST_EDIT_M0 = 3'd4,
        ST_COMMIT  = 3'd5
    } entry_state_e;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    localparam logic [1:0] H1_MAX    = 2'd2;
    localparam logic [3:0] H0_MAX    = 4'd9;
    localparam logic [3:0] H0_MAX_20 = 4'd3;
    localparam logic [3:0] M1_MAX    = 4'd5;
    localparam logic [3:0] M0_MAX    = 4'd9;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic is_edit(input entry_state_e s);
        return (s == ST_EDIT_H1) || (s == ST_EDIT_H0) || (s == ST_EDIT_M1) || (s == ST_EDIT_M0);
    endfunction

    // Raising hour tens to 2 pulls hour units into 0..3 so 24:xx and above can never be formed.
    function automatic hhmm_t inc_digit(input hhmm_t w, input entry_state_e s);
        hhmm_t r;
        r = w;
        case (s)
            ST_EDIT_H1: begin
                r.h1 = (w.h1 >= H1_MAX) ? 2'd0 : w.h1 + 2'd1;
                if ((r.h1 == H1_MAX) && (w.h0 > H0_MAX_20)) begin
                    r.h0 = H0_MAX_20;
                end else begin
                    r.h0 = w.h0;
                end
            end
            ST_EDIT_H0: r.h0 = wrap_inc(w.h0, (w.h1 == H1_MAX) ? H0_MAX_20 : H0_MAX);
            ST_EDIT_M1: r.m1 = wrap_inc(w.m1, M1_MAX);
            ST_EDIT_M0: r.m0 = wrap_inc(w.m0, M0_MAX);
            default:    r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aclock_btn_edge.sv
// Single-bit rising-edge detector for synchronous button levels; a held level yields one pulse.
module aclock_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-sample register for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/aclock_time_entry.sv
// Button-driven HH:MM entry controller feeding the clock core's set interface.
// Define ACLOCK_ENTRY_TIMEOUT_EN to abort an idle edit after TIMEOUT_CYCLES cycles.
module aclock_time_entry
    import aclock_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 12
`ifdef ACLOCK_ENTRY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       target_alm,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] h_set1,
    output logic [3:0] h_set0,
    output logic [3:0] m_set1,
    output logic [3:0] m_set0,
    output logic       set_time,
    output logic       set_alarm,
    output logic       editing,
    output logic [3:0] digit_sel
);

    localparam int SCW = $clog2(STROBE_CYCLES + 1);

    entry_state_e   state_q, state_d;
    hhmm_t          work_q, work_d, out_q, out_d, shadow_q, shadow_d, cur_s;
    logic           tgt_q, tgt_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic           set_time_q, set_time_d, set_alarm_q, set_alarm_d;
    logic           editing_q, editing_d;
    logic [3:0]     digit_sel_q, digit_sel_d;
    logic           edit_rise_s, inc_rise_s, next_rise_s;

    aclock_btn_edge u_edge_edit (.clk(clk), .reset(reset), .btn_i(btn_edit), .rise_o(edit_rise_s));
    aclock_btn_edge u_edge_inc  (.clk(clk), .reset(reset), .btn_i(btn_inc),  .rise_o(inc_rise_s));
    aclock_btn_edge u_edge_next (.clk(clk), .reset(reset), .btn_i(btn_next), .rise_o(next_rise_s));

    assign cur_s = {cur_h1, cur_h0, cur_m1, cur_m0};

`ifdef ACLOCK_ENTRY_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMW-1:0] tmo_q, tmo_d;
`endif

    // Next-state, working-digit and registered-output computation; edit beats next beats inc.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        out_d    = out_q;
        shadow_d = shadow_q;
        tgt_d    = tgt_q;
        scnt_d   = scnt_q;
        case (state_q)
            ST_IDLE: begin
                if (edit_rise_s) begin
                    tgt_d   = target_alm;
                    work_d  = target_alm ? shadow_q : cur_s;
                    state_d = ST_EDIT_H1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
                if (edit_rise_s) begin
                    state_d = ST_IDLE;
                end else if (next_rise_s) begin
                    case (state_q)
                        ST_EDIT_H1: state_d = ST_EDIT_H0;
                        ST_EDIT_H0: state_d = ST_EDIT_M1;
                        ST_EDIT_M1: state_d = ST_EDIT_M0;
                        default: begin
                            state_d = ST_COMMIT;
                            out_d   = work_q;
                            scnt_d  = SCW'(STROBE_CYCLES - 1);
                            if (tgt_q) begin
                                shadow_d = work_q;
                            end else begin
                                shadow_d = shadow_q;
                            end
                        end
                    endcase
                end else if (inc_rise_s) begin
                    work_d = inc_digit(work_q, state_q);
                end else begin
                    work_d = work_q;
                end
            end
            ST_COMMIT: begin
                if (scnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    scnt_d = scnt_q - SCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef ACLOCK_ENTRY_TIMEOUT_EN
        // An idle edit falls back to IDLE exactly like a cancel: no strobe, outputs untouched.
        tmo_d = '0;
        if (is_edit(state_q)) begin
            if (edit_rise_s || inc_rise_s || next_rise_s) begin
                tmo_d = '0;
            end else if (tmo_q == TMW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TMW'(1);
            end
        end else begin
            tmo_d = '0;
        end
`endif

        editing_d = is_edit(state_d);
        case (state_d)
            ST_EDIT_H1: digit_sel_d = 4'b1000;
            ST_EDIT_H0: digit_sel_d = 4'b0100;
            ST_EDIT_M1: digit_sel_d = 4'b0010;
            ST_EDIT_M0: digit_sel_d = 4'b0001;
            default:    digit_sel_d = 4'b0000;
        endcase
        set_time_d  = (state_d == ST_COMMIT) && !tgt_d;
        set_alarm_d = (state_d == ST_COMMIT) && tgt_d;
    end

    // State, digit and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            out_q       <= '0;
            shadow_q    <= '0;
            tgt_q       <= 1'b0;
            scnt_q      <= '0;
            set_time_q  <= 1'b0;
            set_alarm_q <= 1'b0;
            editing_q   <= 1'b0;
            digit_sel_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            out_q       <= out_d;
            shadow_q    <= shadow_d;
            tgt_q       <= tgt_d;
            scnt_q      <= scnt_d;
            set_time_q  <= set_time_d;
            set_alarm_q <= set_alarm_d;
            editing_q   <= editing_d;
            digit_sel_q <= digit_sel_d;
        end
    end

`ifdef ACLOCK_ENTRY_TIMEOUT_EN
    // Idle-cycle counter for the edit timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign h_set1    = out_q.h1;
    assign h_set0    = out_q.h0;
    assign m_set1    = out_q.m1;
    assign m_set0    = out_q.m0;
    assign set_time  = set_time_q;
    assign set_alarm = set_alarm_q;
    assign editing   = editing_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_aclock_time_entry.sv
// Self-checking bench for aclock_time_entry: cycle model of the entry rules plus directed literal checks.
module tb_aclock_time_entry;

    localparam int STROBE = 12;
`ifdef ACLOCK_ENTRY_TIMEOUT_EN
    localparam int TMO = 20;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_edit = 1'b0, btn_inc = 1'b0, btn_next = 1'b0, target_alm = 1'b0;
    logic [1:0] cur_h1 = 2'd0;
    logic [3:0] cur_h0 = 4'd0, cur_m1 = 4'd0, cur_m0 = 4'd0;
    logic [1:0] h_set1;
    logic [3:0] h_set0, m_set1, m_set0, digit_sel;
    logic       set_time, set_alarm, editing;

    int checks = 0;
    int errors = 0;

    aclock_time_entry #(
        .STROBE_CYCLES(STROBE)
`ifdef ACLOCK_ENTRY_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk), .reset(reset), .btn_edit(btn_edit), .btn_inc(btn_inc), .btn_next(btn_next),
        .target_alm(target_alm), .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .h_set1(h_set1), .h_set0(h_set0), .m_set1(m_set1), .m_set0(m_set0),
        .set_time(set_time), .set_alarm(set_alarm), .editing(editing), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    // pos: 0 idle, 1..4 editing digit H1,H0,M1,M0, 5 committing
    typedef struct packed {
        int pos; int tgt; int cnt; int idle;
        int w_h1; int w_h0; int w_m1; int w_m0;
        int o_h1; int o_h0; int o_m1; int o_m0;
        int s_h1; int s_h0; int s_m1; int s_m0;
        int pe; int pi; int pn;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, int el, int il, int nl, int alm,
                                          int c1, int c0, int c3, int c2);
        model_t r;
        int e, i, n;
        r = c;
        e = (el != 0 && c.pe == 0) ? 1 : 0;
        i = (il != 0 && c.pi == 0) ? 1 : 0;
        n = (nl != 0 && c.pn == 0) ? 1 : 0;
        r.pe = el; r.pi = il; r.pn = nl;
        if (c.pos == 0) begin
            if (e != 0) begin
                r.tgt = alm; r.pos = 1; r.idle = 0;
                if (alm != 0) begin
                    r.w_h1 = c.s_h1; r.w_h0 = c.s_h0; r.w_m1 = c.s_m1; r.w_m0 = c.s_m0;
                end else begin
                    r.w_h1 = c1; r.w_h0 = c0; r.w_m1 = c3; r.w_m0 = c2;
                end
            end
        end else if (c.pos == 5) begin
            r.cnt = c.cnt - 1;
            if (r.cnt == 0) r.pos = 0;
        end else begin
            if (e != 0) begin
                r.pos = 0;
            end else if (n != 0) begin
                if (c.pos == 4) begin
                    r.pos = 5; r.cnt = STROBE;
                    r.o_h1 = c.w_h1; r.o_h0 = c.w_h0; r.o_m1 = c.w_m1; r.o_m0 = c.w_m0;
                    if (c.tgt != 0) begin
                        r.s_h1 = c.w_h1; r.s_h0 = c.w_h0; r.s_m1 = c.w_m1; r.s_m0 = c.w_m0;
                    end
                end else begin
                    r.pos = c.pos + 1;
                end
            end else if (i != 0) begin
                case (c.pos)
                    1: begin
                        r.w_h1 = (c.w_h1 + 1) % 3;
                        if (r.w_h1 == 2 && c.w_h0 > 3) r.w_h0 = 3;
                    end
                    2: r.w_h0 = (c.w_h0 + 1) % ((c.w_h1 == 2) ? 4 : 10);
                    3: r.w_m1 = (c.w_m1 + 1) % 6;
                    default: r.w_m0 = (c.w_m0 + 1) % 10;
                endcase
            end
`ifdef ACLOCK_ENTRY_TIMEOUT_EN
            if (r.pos >= 1 && r.pos <= 4) begin
                if (e != 0 || i != 0 || n != 0) begin
                    r.idle = 0;
                end else begin
                    r.idle = c.idle + 1;
                    if (r.idle == TMO) r.pos = 0;
                end
            end
`endif
        end
        return r;
    endfunction

    // Model advances on the same edges as the DUT; reset is asynchronous.
    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else m <= model_next(m, int'(btn_edit), int'(btn_inc), int'(btn_next), int'(target_alm),
                             int'(cur_h1), int'(cur_h0), int'(cur_m1), int'(cur_m0));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_h_set1", int'(h_set1), m.o_h1);
            chk("m_h_set0", int'(h_set0), m.o_h0);
            chk("m_m_set1", int'(m_set1), m.o_m1);
            chk("m_m_set0", int'(m_set0), m.o_m0);
            chk("m_set_time", int'(set_time), (m.pos == 5 && m.tgt == 0) ? 1 : 0);
            chk("m_set_alarm", int'(set_alarm), (m.pos == 5 && m.tgt != 0) ? 1 : 0);
            chk("m_editing", int'(editing), (m.pos >= 1 && m.pos <= 4) ? 1 : 0);
            chk("m_digit_sel", int'(digit_sel), (m.pos >= 1 && m.pos <= 4) ? (8 >> (m.pos - 1)) : 0);
        end
    end

    // Strobe run-length monitor.
    int st_run = 0, st_last = 0, st_runs = 0, al_run = 0, al_last = 0;
    always @(negedge clk) begin
        if (reset) begin
            st_run <= 0; al_run <= 0;
        end else begin
            if (set_time) st_run <= st_run + 1;
            else if (st_run > 0) begin st_last <= st_run; st_runs <= st_runs + 1; st_run <= 0; end
            if (set_alarm) al_run <= al_run + 1;
            else if (al_run > 0) begin al_last <= al_run; al_run <= 0; end
        end
    end

    task automatic press(input bit e, input bit i, input bit n);
        @(posedge clk); #2;
        btn_edit = e; btn_inc = i; btn_next = n;
        @(posedge clk); #2;
        btn_edit = 1'b0; btn_inc = 1'b0; btn_next = 1'b0;
    endtask

    task automatic set_cur(input int a, input int b, input int c, input int d);
        cur_h1 = 2'(a); cur_h0 = 4'(b); cur_m1 = 4'(c); cur_m0 = 4'(d);
    endtask

    task automatic chk_out(input string name, input int a, input int b, input int c, input int d);
        chk({name, "_h1"}, int'(h_set1), a);
        chk({name, "_h0"}, int'(h_set0), b);
        chk({name, "_m1"}, int'(m_set1), c);
        chk({name, "_m0"}, int'(m_set0), d);
    endtask

    initial begin
        int runs_before;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk_out("rst", 0, 0, 0, 0);
        chk("rst_strobe", int'(set_time) + int'(set_alarm) + int'(editing) + int'(digit_sel), 0);

        // Time commit of 12:34 unchanged
        set_cur(1, 2, 3, 4); target_alm = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_edit", int'(editing), 1);
        chk("t1_sel", int'(digit_sel), 8);
        repeat (4) press(1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_out("t1", 1, 2, 3, 4);
        chk("t1_strobe_len", st_last, 12);
        chk("t1_no_alarm", al_last, 0);

        // Alarm 09:00, then raise hour tens to 2 so units clamp: 23:00
        target_alm = 1'b1; set_cur(1, 7, 5, 5);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (9) press(1'b0, 1'b1, 1'b0);
        repeat (3) press(1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_out("a1", 0, 9, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        repeat (2) press(1'b0, 1'b1, 1'b0);
        repeat (4) press(1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_out("a2", 2, 3, 0, 0);
        chk("a2_strobe_len", al_last, 12);

        // Wraps: H1 2->0 (H0 kept), held inc counts once, M1 5->0, M0 9->0
        target_alm = 1'b0; set_cur(2, 1, 5, 9);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        @(posedge clk); #2 btn_inc = 1'b1;
        repeat (3) @(posedge clk);
        #2 btn_inc = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_out("wrap", 0, 2, 0, 0);

        // inc+next together: only next; edit+next together: cancel
        set_cur(1, 2, 3, 4);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("pri_sel", int'(digit_sel), 4);
        press(1'b0, 1'b1, 1'b1);
        press(1'b0, 1'b1, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_out("pri", 1, 2, 3, 4);
        runs_before = st_runs;
        set_cur(0, 0, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("cancel_edit", int'(editing), 0);
        chk("cancel_runs", st_runs, runs_before);
        chk_out("cancel", 1, 2, 3, 4);

        // Idle edit: persists by default, times out when enabled
        press(1'b1, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
`ifdef ACLOCK_ENTRY_TIMEOUT_EN
        chk("idle_edit", int'(editing), 0);
`else
        chk("idle_edit", int'(editing), 1);
        press(1'b1, 1'b0, 1'b0);
`endif
        chk("idle_runs", st_runs, runs_before);

        // Reset during strobe cycle 5
        set_cur(0, 5, 5, 0);
        press(1'b1, 1'b0, 1'b0);
        repeat (3) press(1'b0, 1'b0, 1'b1);
        @(posedge clk); #2 btn_next = 1'b1;
        @(posedge clk); #2 btn_next = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rs_before", int'(set_time), 1);
        chk_out("rs_before", 0, 5, 5, 0);
        #1 reset = 1'b1;
        #1;
        chk("rs_strobe", int'(set_time), 0);
        chk("rs_editing", int'(editing), 0);
        chk_out("rs", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rs_idle", int'(editing) + int'(set_time), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
